// File: rtl/rans_encoder_param.sv
// Streaming rANS encoder: power-of-two total, sequential restoring divider, explicit flush.
// Optional sticky input-legality flag: define RANS_ENC_ERR_CHECK_EN to add the err port.
module rans_encoder_param #(
  parameter int unsigned STATE_W    = 16,
  parameter int unsigned OUT_W      = 4,
  parameter int unsigned SCALE_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [SCALE_BITS:0]   s_count,
  input  logic [SCALE_BITS-1:0] s_cumulative,
  input  logic                  in_flush,
  input  logic                  in_vld,
  output logic                  in_rdy,
  output logic [OUT_W-1:0]      out,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  out_last,
  output logic                  busy
`ifdef RANS_ENC_ERR_CHECK_EN
  ,
  output logic                  err
`endif
);

  localparam int unsigned F_W    = SCALE_BITS + 1;
  localparam int unsigned NWORDS = STATE_W / OUT_W;
  localparam int unsigned CNT_W  = $clog2(STATE_W + 1);

  localparam logic [STATE_W-1:0] L_VAL     = STATE_W'(1) << (STATE_W - OUT_W);
  localparam logic [STATE_W:0]   XMAX_UNIT = (STATE_W + 1)'(1) << (STATE_W - SCALE_BITS);

  typedef enum logic [2:0] {IDLE, RENORM, DIV, UPDATE, FLUSH} state_e;

  state_e               state_q, state_d;
  logic [STATE_W-1:0]   x_q, x_d;
  logic [F_W-1:0]       f_q, f_d;
  logic [SCALE_BITS-1:0] c_q, c_d;
  logic [STATE_W-1:0]   quo_q, quo_d;
  logic [F_W-1:0]       rem_q, rem_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [STATE_W:0]     x_max;
  logic                 need_renorm;
  logic                 last_word;
  logic                 div_done;
  logic [F_W:0]         rem_sh, f_ext, rem_sub;
  logic                 div_ge;
  logic [STATE_W-1:0]   x_upd;
  logic                 accept;

  assign x_max       = XMAX_UNIT * (STATE_W + 1)'(f_q);
  assign need_renorm = {1'b0, x_q} >= x_max;
  assign last_word   = (cnt_q == CNT_W'(NWORDS - 1));
  assign div_done    = (cnt_q == CNT_W'(STATE_W - 1));

  // One restoring-division step: quotient bits shift in from the bottom of quo_q.
  assign rem_sh  = {rem_q, quo_q[STATE_W-1]};
  assign f_ext   = {1'b0, f_q};
  assign div_ge  = rem_sh >= f_ext;
  assign rem_sub = rem_sh - f_ext;

  assign x_upd  = (quo_q << SCALE_BITS) + STATE_W'(rem_q) + STATE_W'(c_q);
  assign accept = in_vld && in_rdy;

`ifdef RANS_ENC_ERR_CHECK_EN
  logic         err_q, err_d;
  logic [F_W:0] cf_sum;
  logic         illegal;

  assign cf_sum  = (F_W + 1)'(s_cumulative) + (F_W + 1)'(s_count);
  assign illegal = (s_count == '0) || (cf_sum > ((F_W + 1)'(1) << SCALE_BITS));
  assign err     = err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= L_VAL;
      f_q     <= '0;
      c_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
`ifdef RANS_ENC_ERR_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      f_q     <= f_d;
      c_q     <= c_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
`ifdef RANS_ENC_ERR_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    f_d     = f_q;
    c_d     = c_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
`ifdef RANS_ENC_ERR_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_flush) begin
            cnt_d   = '0;
            state_d = FLUSH;
          end else begin
`ifdef RANS_ENC_ERR_CHECK_EN
            if (illegal) begin
              err_d = 1'b1;
            end else begin
              f_d     = s_count;
              c_d     = s_cumulative;
              state_d = RENORM;
            end
`else
            f_d     = s_count;
            c_d     = s_cumulative;
            state_d = RENORM;
`endif
          end
        end
      end
      RENORM: begin
        if (ena) begin
          if (need_renorm) begin
            if (out_rdy) x_d = x_q >> OUT_W;
          end else begin
            quo_d   = x_q;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = DIV;
          end
        end
      end
      DIV: begin
        if (ena) begin
          quo_d = {quo_q[STATE_W-2:0], div_ge};
          rem_d = F_W'(div_ge ? rem_sub : rem_sh);
          cnt_d = cnt_q + 1'b1;
          if (div_done) state_d = UPDATE;
        end
      end
      UPDATE: begin
        if (ena) begin
          x_d     = x_upd;
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (ena && out_rdy) begin
          x_d   = x_q >> OUT_W;
          cnt_d = cnt_q + 1'b1;
          if (last_word) begin
            x_d     = L_VAL;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_rdy   = 1'b0;
    out      = '0;
    out_vld  = 1'b0;
    out_last = 1'b0;
    busy     = (state_q != IDLE);
    case (state_q)
      IDLE:   in_rdy = ena && !rst;
      RENORM: begin
        if (need_renorm) begin
          out     = x_q[OUT_W-1:0];
          out_vld = ena;
        end
      end
      FLUSH: begin
        out      = x_q[OUT_W-1:0];
        out_vld  = ena;
        out_last = ena && last_word;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/rans_encoder_param.md
Name: rans_encoder_param

Overview:
- Parametrised successor to the fixed-width ANS encoder. Implements a streaming rANS encoder with configurable state, output-word and probability-scale widths.
- Uses a power-of-two total (2^SCALE_BITS) and a sequential divider, so no wide combinational divide is needed.
- Adds an explicit flush/terminate mode that drains the final state and marks the last word.
- Sits between the symbol-frequency lookup and the output word packer.

Parameters:
- STATE_W, 16: encoder state width x. Must be a multiple of OUT_W.
- OUT_W, 4: renormalisation output word width.
- SCALE_BITS, 8: log2 of total frequency M. Must satisfy STATE_W-OUT_W >= SCALE_BITS.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  design enable. When low, all state is held, in_rdy=0 and out_vld=0.
- s_count  in  SCALE_BITS+1  symbol frequency f, legal range 1..2^SCALE_BITS.
- s_cumulative  in  SCALE_BITS  cumulative frequency c.
- in_flush  in  1  sideband qualified by in_vld. 1 = flush request; s_count/s_cumulative are ignored.
- in_vld  in  1  symbol/flush request valid.
- in_rdy  out  1  encoder ready to accept a request.
- out  out  OUT_W  emitted state word.
- out_vld  out  1  out valid.
- out_rdy  in  1  downstream ready.
- out_last  out  1  final word of a flush, qualified by out_vld.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Constants: L = 2^(STATE_W-OUT_W). Invariant: x in [L, L*2^OUT_W). x_max(f) = ((L>>SCALE_BITS)<<OUT_W)*f, computed in STATE_W+1 bits.
- Reset (async, any state, including mid-divide or mid-flush):
  - x = L, state = IDLE, divider cleared.
  - Outputs: in_rdy=0 while rst is high; out=0, out_vld=0, out_last=0, busy=0.
- Handshakes:
  - A transfer occurs on the clock edge where vld && rdy && ena.
  - out and out_last stay stable while out_vld=1 && out_rdy=0.
  - in_rdy=1 only in IDLE with ena=1.
- FSM states:
  - IDLE: on accept, latch f, c and flush. If flush -> FLUSH, else -> RENORM.
  - RENORM: if x >= x_max(f), drive out_vld=1, out=x[OUT_W-1:0]. On handshake, x <= x >> OUT_W and stay in RENORM. If x < x_max(f), -> DIV on the next edge (one check cycle, no output).
  - DIV: restoring divider, exactly STATE_W cycles, producing q = x/f and r = x%f (f>0 guaranteed), then -> UPDATE.
  - UPDATE: x <= (q << SCALE_BITS) + r + c, truncated to STATE_W bits (cannot overflow for legal inputs), then -> IDLE.
  - FLUSH: emit STATE_W/OUT_W words of x, least-significant word first, one per handshake. out_last=1 on the final word. After the final handshake, x <= L and -> IDLE.
- Latency:
  - Accept to next in_rdy without renorm = STATE_W+2 cycles.
  - Each renorm word adds at least 1 cycle, plus backpressure stall cycles.
- Output order: the stream is LIFO per rANS; the decoder consumes it reversed.
- Boundary conditions:
  - f = 2^SCALE_BITS never renormalises.
  - A flush immediately after reset emits L's words.
  - in_vld during a non-IDLE state is ignored (in_rdy=0).
  - ena low mid-RENORM holds x and the word; out_vld reasserts when ena returns.

Optional Feature:
- Macro: RANS_ENC_ERR_CHECK_EN.
- When defined:
  - Adds output err (1 bit, sticky, cleared only by rst).
  - On accept of a non-flush request with f==0 or c+f > 2^SCALE_BITS: err <= 1, the request is dropped, x is unchanged, and the FSM stays in IDLE.
- When undefined: no err port, no check. Illegal input yields undefined x, but the FSM still returns to IDLE (a divide by zero terminates after STATE_W cycles).

Test Plan:
- Defaults, reset then encode f=128, c=0 -> no output word, in_rdy returns after 18 cycles, next flush emits 0,0,0,2 (x=0x2000).
- From x=0x2000, encode f=16, c=128 -> one word 0x0 emitted, then x=0x2080. Flush emits 0x0, 0x8, 0x0, 0x2 with out_last only on 0x2. Afterwards x=0x1000.
- Backpressure: hold out_rdy=0 for 5 cycles during the renorm in the previous case -> out=0x0 and out_vld=1 stable for all 5 cycles, exactly one word transferred.
- Reset: assert rst for 1 cycle in the 7th DIV cycle -> in_rdy=0 while rst is high, in_rdy=1 on the first edge after release, busy=0, out_vld=0. A following flush emits 0,0,0,1.
- ena=0 for 3 cycles mid-flush -> no transfers and out_vld=0. The flush resumes at the same word, with a total of 4 words.
- With RANS_ENC_ERR_CHECK_EN: encode f=0 -> err=1, in_rdy stays 1, and a subsequent flush emits 0,0,0,1.
